// File: rtl/count_bcd_capture.sv
// Captures an asynchronous binary count once two consecutive samples agree,
// then converts it to packed BCD with one double-dabble step per clock.
module count_bcd_capture #(
  parameter int unsigned width_cnt = 26,
  parameter int unsigned digits    = 8,
  parameter int unsigned retry_max = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [width_cnt-1:0]   cnt_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [4*digits-1:0]    bcd,
  output logic                   unstable
);

  localparam int unsigned BCD_W   = 4 * digits;
  localparam int unsigned STEP_W  = $clog2(width_cnt + 1);
  localparam int unsigned RETRY_W = $clog2(retry_max + 1);

  typedef enum logic [1:0] {IDLE, CAP, CONV} state_t;

  state_t               r_state;
  logic [width_cnt-1:0] r_a;
  logic [width_cnt-1:0] r_shift;
  logic [BCD_W-1:0]     r_acc;
  logic [STEP_W-1:0]    r_step;
  logic [RETRY_W-1:0]   r_cmp;
  logic                 r_flag;

  logic [BCD_W-1:0]     w_adj;
  logic [BCD_W-1:0]     w_acc_next;
  logic [width_cnt-1:0] w_shift_next;

  // One double-dabble step: +3 on digits >= 5, then shift {acc, shift} left.
  always_comb begin
    w_adj = r_acc;
    for (int unsigned d = 0; d < digits; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
    {w_acc_next, w_shift_next} = {w_adj[BCD_W-2:0], r_shift, 1'b0};
  end

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_shift  <= '0;
      r_acc    <= '0;
      r_step   <= '0;
      r_cmp    <= '0;
      r_flag   <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      unstable <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= cnt_in;
            r_cmp   <= '0;
            r_state <= CAP;
          end
        end
        CAP: begin
          r_cmp <= r_cmp + RETRY_W'(1);
          if (cnt_in == r_a) begin
            r_shift <= r_a;
            r_acc   <= '0;
            r_step  <= '0;
            r_flag  <= 1'b0;
            r_state <= CONV;
          end else if (r_cmp == RETRY_W'(retry_max - 1)) begin
            // Out of retries: convert whatever is on the bus now and flag it.
            r_shift <= cnt_in;
            r_acc   <= '0;
            r_step  <= '0;
            r_flag  <= 1'b1;
            r_state <= CONV;
          end else begin
            r_a <= cnt_in;
          end
        end
        CONV: begin
          r_acc   <= w_acc_next;
          r_shift <= w_shift_next;
          if (r_step == STEP_W'(width_cnt - 1)) begin
            bcd      <= w_acc_next;
            unstable <= r_flag;
            done     <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_step <= r_step + STEP_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_bcd_capture.sv
// Directed bench for count_bcd_capture: latency, BCD results, retry/unstable
// behaviour, ignored restarts, clear-abort and back-to-back captures.
module tb_count_bcd_capture;

  localparam int unsigned W = 26;
  localparam int unsigned D = 8;
  localparam int unsigned R = 4;

  logic           clk = 1'b0;
  logic           clr;
  logic [W-1:0]   cnt_in;
  logic           start;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;
  logic           unstable;

  int checks   = 0;
  int failures = 0;

  count_bcd_capture #(.width_cnt(W), .digits(D), .retry_max(R)) dut (
    .clk(clk), .clr(clr), .cnt_in(cnt_in), .start(start),
    .busy(busy), .done(done), .bcd(bcd), .unstable(unstable)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic [W-1:0] v);
    cnt_in = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Counts cycles after the start edge until done (bounded); optionally churns cnt_in
  // every cycle and/or pulses start again at cycle restart_at.
  task automatic wait_done(input bit churn, input int restart_at,
                           output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_cnt++;
      if (churn) cnt_in = cnt_in + W'(1);
      if (lat == restart_at) begin
        start  = 1'b1;
        cnt_in = W'(5555);
      end else if (lat == restart_at + 1) begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b1; cnt_in = W'(123);
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || unstable !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b done=%b unstable=%b want 0 0 0", busy, done, unstable);
    end
    checks++;
    if (bcd !== 32'h0) begin
      failures++;
      $display("FAIL reset_bcd: got %h want 00000000", bcd);
    end
    clr = 1'b0; start = 1'b0;
  endtask

  task automatic test_stable();
    int lat, bc;
    launch(W'(12345678));
    wait_done(1'b0, -1, lat, bc);
    checks++;
    if (lat !== 27) begin failures++; $display("FAIL stable_latency: got %0d want 27", lat); end
    checks++;
    if (bc !== 27) begin failures++; $display("FAIL stable_busy_cycles: got %0d want 27", bc); end
    checks++;
    if (bcd !== 32'h12345678 || unstable !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stable_result: bcd=%h unstable=%b busy=%b want 12345678 0 0", bcd, unstable, busy);
    end
    cnt_in = W'(5);
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width: done=%b want 0", done); end
    tick(); tick();
    checks++;
    if (bcd !== 32'h12345678 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: bcd=%h busy=%b want 12345678 0", bcd, busy);
    end
  endtask

  task automatic test_all_ones();
    int lat, bc;
    launch(W'(67108863));
    wait_done(1'b0, -1, lat, bc);
    checks++;
    if (lat !== 27 || bcd !== 32'h67108863) begin
      failures++;
      $display("FAIL all_ones: lat=%0d bcd=%h want 27 67108863", lat, bcd);
    end
    tick();
  endtask

  task automatic test_unstable();
    int lat, bc;
    launch(W'(1000));
    wait_done(1'b1, -1, lat, bc);
    checks++;
    if (lat !== 30 || bc !== 30) begin
      failures++;
      $display("FAIL unstable_latency: lat=%0d busy=%0d want 30 30", lat, bc);
    end
    checks++;
    if (unstable !== 1'b1 || bcd !== 32'h00001004) begin
      failures++;
      $display("FAIL unstable_result: unstable=%b bcd=%h want 1 00001004", unstable, bcd);
    end
    tick();
  endtask

  task automatic test_zero();
    int lat, bc;
    launch(W'(0));
    wait_done(1'b0, -1, lat, bc);
    checks++;
    if (lat !== 27 || bcd !== 32'h0 || unstable !== 1'b0) begin
      failures++;
      $display("FAIL zero: lat=%0d bcd=%h unstable=%b want 27 00000000 0", lat, bcd, unstable);
    end
    tick();
  endtask

  task automatic test_restart_ignored();
    int lat, bc, extra;
    launch(W'(4321));
    wait_done(1'b0, 10, lat, bc);
    checks++;
    if (lat !== 27 || bcd !== 32'h00004321) begin
      failures++;
      $display("FAIL restart_ignored: lat=%0d bcd=%h want 27 00004321", lat, bcd);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL restart_not_queued: active cycles %0d want 0", extra); end
  endtask

  task automatic test_clr_abort();
    int lat, bc;
    launch(W'(777));
    for (int i = 0; i < 10; i++) tick();
    clr = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 32'h0 || unstable !== 1'b0) begin
      failures++;
      $display("FAIL clr_abort: busy=%b done=%b bcd=%h unstable=%b want 0 0 0 0", busy, done, bcd, unstable);
    end
    clr = 1'b0;
    launch(W'(999));
    wait_done(1'b0, -1, lat, bc);
    checks++;
    if (lat !== 27 || bcd !== 32'h00000999) begin
      failures++;
      $display("FAIL clr_then_start: lat=%0d bcd=%h want 27 00000999", lat, bcd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n, first, second, bad;
    bit pend;
    n = 0; first = -1; second = -1; bad = 0; pend = 1'b0;
    cnt_in = W'(31415926);
    start  = 1'b1;
    tick();
    for (int lat = 1; lat <= 115; lat++) begin
      tick();
      if (done === 1'b1) begin
        if (n == 0) first = lat;
        else if (n == 1) second = lat;
        n++;
        pend = 1'b1;
      end else if (pend) begin
        if (busy !== 1'b1) bad++;
        pend = 1'b0;
      end
    end
    checks++;
    if (n !== 4 || first !== 27 || second !== 55) begin
      failures++;
      $display("FAIL b2b_cadence: pulses=%0d first=%0d second=%0d want 4 27 55", n, first, second);
    end
    checks++;
    if (bad !== 0 || bcd !== 32'h31415926) begin
      failures++;
      $display("FAIL b2b_result: no_busy_after_done=%0d bcd=%h want 0 31415926", bad, bcd);
    end
    start = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; cnt_in = '0;
    @(negedge clk);
    test_reset();
    test_stable();
    test_all_ones();
    test_unstable();
    test_zero();
    test_restart_ignored();
    test_clr_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
